// File: rtl/pmt_pkg.sv
// Shared definitions for the PMT bin-count UART reader.
// Holds the UART FSM state encoding and the frame and baud defaults.
// Imported by the count FIFO and by the top-level transmitter.
package pmt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/pmt_sync_fifo.sv
// Synchronous FIFO holding captured bin counts until the UART can send them.
// Latency: a write is visible at the head on the next cycle; rd_data is combinational.
// Backpressure: a write when full is ignored unless a read happens in the same cycle.
module pmt_sync_fifo
  import pmt_pkg::*;
#(
  parameter int WIDTH = UART_DATA_BITS,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level
);

  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   LVL_ONE  = 1;
  localparam logic [PTR_W:0]   LVL_FULL = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_push;
  logic             w_pop;

  // A read in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign w_pop   = rd_en && !empty;
  assign w_push  = wr_en && (!full || w_pop);
  assign full    = (r_level == LVL_FULL);
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign rd_data = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/pmt_bin_uart_tx.sv
// Captures PMT timebin counts on the bin-end pulse and sends each as one 8N1 byte, LSB first.
// Latency: strobe at edge N into an empty idle block gives the start bit from edge N+1.
// Backpressure: counts queue in the FIFO; a strobe with the FIFO full is dropped and flags overflow.
module pmt_bin_uart_tx
  import pmt_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16,
  localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           bin_strobe,
  input  logic [7:0]     bin_count,
  output logic           tx,
  output logic           busy,
  output logic [PTR_W:0] fifo_level,
  output logic           overflow,
  output logic           LED
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_t r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_busy;
  logic        r_led;
  logic        r_overflow;

  logic [7:0]  w_rd_data;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_baud_done;

  // The only place a byte leaves the queue is the IDLE cycle that launches a frame.
  assign w_pop       = (r_state == IDLE) && !w_empty;
  assign w_baud_done = (r_baud == BAUD_LAST);

  pmt_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bin_strobe),
    .wr_data (bin_count),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  // Sticky drop flag: only a strobe that finds the FIFO full with no same-cycle pop is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (bin_strobe && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  // UART frame sequencer with registered line, busy and LED outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_led     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx      <= 1'b1;
          r_busy    <= 1'b0;
          r_baud    <= '0;
          r_bit_cnt <= '0;
          if (!w_empty) begin
            r_shift <= w_rd_data;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              r_tx      <= 1'b1;
              r_state   <= STOP;
            end else begin
              // Present the next bit in the same edge that shifts it down to bit 0.
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        STOP: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_busy  <= 1'b0;
            r_led   <= ~r_led;
            r_state <= IDLE;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign LED      = r_led;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_pmt_bin_uart_tx.sv
// Randomised and directed bench for pmt_bin_uart_tx with a line-level UART receiver.
// Expected bytes are queued when a strobe is accepted and popped by the receiver.
// A cycle-count reference model also predicts tx, busy, level, overflow and LED.
module tb_pmt_bin_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bin_strobe = 1'b0;
  logic [7:0]    bin_count = 8'h00;
  logic          tx;
  logic          busy;
  logic [PW:0]   fifo_level;
  logic          overflow;
  logic          LED;

  pmt_bin_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bin_strobe (bin_strobe),
    .bin_count  (bin_count),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .LED        (LED)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] mq[$];       // bytes waiting in the queue
  logic [7:0] sb[$];       // bytes expected on the line, in order
  int         frame_left = 0;  // cycles left in the frame on the line (0 = idle)
  logic [7:0] cur = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_led = 1'b0;
  bit         rst_seen = 1'b0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Apply what the block should do at one clock edge.
  function automatic void model_edge(bit s, logic [7:0] v, bit r);
    if (r) begin
      mq.delete();
      sb.delete();
      frame_left = 0;
      m_ovf = 1'b0;
      m_led = 1'b0;
      return;
    end
    if (frame_left == 0 && mq.size() > 0) begin
      cur = mq.pop_front();
      frame_left = 10 * CPB;
    end else if (frame_left > 0) begin
      frame_left--;
      if (frame_left == 0) m_led = ~m_led;
    end
    if (s) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(v);
        sb.push_back(v);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endfunction

  function automatic void check_outputs();
    int   elapsed;
    int   bitn;
    logic exp_tx;
    exp_tx = 1'b1;
    if (frame_left > 0) begin
      elapsed = 10 * CPB - frame_left;
      bitn = elapsed / CPB;
      if (bitn == 0)      exp_tx = 1'b0;
      else if (bitn <= 8) exp_tx = cur[bitn-1];
      else                exp_tx = 1'b1;
    end
    chk("tx", int'(tx), int'(exp_tx));
    chk("busy", int'(busy), (frame_left > 0) ? 1 : 0);
    chk("fifo_level", int'(fifo_level), mq.size());
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("LED", int'(LED), int'(m_led));
  endfunction

  task automatic tick(input bit s, input logic [7:0] v, input bit r);
    bin_strobe = s;
    bin_count  = v;
    reset      = r;
    @(posedge clk);
    model_edge(s, v, r);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  // Note resets so the receiver drops any partial frame.
  always @(posedge clk) begin
    if (reset) rst_seen = 1'b1;
  end

  // Line receiver: decode each frame mid-bit and compare against the expected queue.
  initial begin : monitor
    bit         active;
    int         cnt;
    int         bitn;
    logic [7:0] rx;
    logic [7:0] exp_b;
    active = 1'b0;
    cnt = 0;
    rx = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        rst_seen = 1'b0;
        active = 1'b0;
      end else begin
        if (!active && tx === 1'b0) begin
          active = 1'b1;
          cnt = 0;
        end
        if (active) begin
          if (cnt % CPB == CPB / 2) begin
            bitn = cnt / CPB;
            if (bitn == 0) begin
              chk("rx_start", int'(tx), 0);
            end else if (bitn <= 8) begin
              rx[bitn-1] = tx;
            end else begin
              chk("rx_stop", int'(tx), 1);
              if (sb.size() == 0) begin
                chk("rx_unexpected_byte", int'(rx), -1);
              end else begin
                exp_b = sb.pop_front();
                chk("rx_byte", int'(rx), int'(exp_b));
              end
              active = 1'b0;
            end
          end
          cnt++;
        end
      end
    end
  end

  initial begin : stim
    int peak;
    int guard;
    logic [7:0] v;

    // Reset, then a long quiet idle
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    idle(100);
    chk("idle_tx", int'(tx), 1);
    chk("idle_level", int'(fifo_level), 0);

    // Single byte: start bit one edge after the strobe edge, LED toggles at stop end
    tick(1'b1, 8'hA5, 1'b0);
    chk("strobe_edge_tx", int'(tx), 1);
    tick(1'b0, 8'h00, 1'b0);
    chk("latency_tx", int'(tx), 0);
    idle(50);
    chk("led_after_a5", int'(LED), 1);

    // Three consecutive strobes
    peak = 0;
    tick(1'b1, 8'h01, 1'b0);
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
    tick(1'b1, 8'h02, 1'b0);
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
    tick(1'b1, 8'hFF, 1'b0);
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
    for (int i = 0; i < 140; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    chk("peak_level", peak, 2);
    chk("drained_busy", int'(busy), 0);
    chk("drained_level", int'(fifo_level), 0);

    // Overflow: six strobes, sixth dropped
    for (int i = 0; i < 6; i++) begin
      v = 8'h10 + 8'(i);
      tick(1'b1, v, 1'b0);
    end
    chk("ovf_set", int'(overflow), 1);
    idle(230);
    chk("ovf_sticky", int'(overflow), 1);

    // Full FIFO with a strobe coinciding with the pop
    tick(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      v = 8'h20 + 8'(i);
      tick(1'b1, v, 1'b0);
    end
    guard = 0;
    while (!(frame_left == 0 && mq.size() == DEPTH) && guard < 200) begin
      tick(1'b0, 8'h00, 1'b0);
      guard++;
    end
    if (guard >= 200) chk("wait_pop_timeout", guard, 0);
    tick(1'b1, 8'h77, 1'b0);
    chk("coincide_level", int'(fifo_level), 4);
    chk("coincide_ovf", int'(overflow), 0);
    idle(250);

    // Reset in the middle of data bit 3 with two entries queued
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h3C, 1'b0);
    tick(1'b1, 8'h55, 1'b0);
    tick(1'b1, 8'h66, 1'b0);
    guard = 0;
    while (!(frame_left > 0 && (10 * CPB - frame_left) == 4 * CPB + 1) && guard < 100) begin
      tick(1'b0, 8'h00, 1'b0);
      guard++;
    end
    if (guard >= 100) chk("wait_bit3_timeout", guard, 0);
    chk("pre_reset_level", int'(fifo_level), 2);
    tick(1'b0, 8'h00, 1'b1);
    chk("abort_tx", int'(tx), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_level", int'(fifo_level), 0);
    idle(100);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        tick(1'b0, 8'h00, 1'b1);
      end else begin
        v = 8'($urandom_range(0, 255));
        tick(($urandom_range(0, 24) == 0), v, 1'b0);
      end
    end
    idle(300);
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
